// File: rtl/seq_alu_if.sv
// Handshake and operand/result bundle between the control unit and seq_alu.
interface seq_alu_if #(
  parameter int W = 32
);
  logic           start;
  logic [3:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           done;
  logic [2*W-1:0] z;
  logic           div0;

  // Control unit side: issues requests, observes results.
  modport master (
    output start, op, a, b,
    input  ready, done, z, div0
  );

  // ALU side: accepts requests, produces results.
  modport slave (
    input  start, op, a, b,
    output ready, done, z, div0
  );
endinterface

// File: rtl/seq_alu.sv
// Registered miniSRC ALU. Simple ops finish in one cycle; signed multiply
// (radix-2 Booth) and signed divide (restoring, on magnitudes) take one
// iteration per cycle. The 2W-bit result feeds the HI/LO and Z registers.
module seq_alu #(
  parameter  int W  = 32,
  localparam int SW = $clog2(W)
) (
  input  logic     clk,
  input  logic     clear_n,
  seq_alu_if.slave bus
);

  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Single-cycle operations; MUL/DIV never reach this function.
  function automatic logic [W-1:0] simple_op(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [SW-1:0]  amt;
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] tmp;
    logic [W-1:0]   res;
    amt = b[SW-1:0];
    dbl = {a, a};
    tmp = '0;
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SHR:  res = a >> amt;
      OP_SHRA: res = $signed(a) >>> amt;
      OP_SHL:  res = a << amt;
      OP_ROR: begin
        tmp = dbl >> amt;
        res = tmp[W-1:0];
      end
      OP_ROL: begin
        tmp = dbl << amt;
        res = tmp[2*W-1:W];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NEG:  res = -a;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
    return res;
  endfunction

  // One Booth iteration: conditional add/sub of the multiplicand into the
  // W+1 bit accumulator (the extra bit keeps -(-2^(W-1)) representable),
  // then arithmetic shift of {acc, qr, qm1}. Returns {acc, qr, qm1}.
  function automatic logic [2*W+1:0] booth_step(input logic signed [W:0]   acc,
                                                input logic [W-1:0]       qr,
                                                input logic               qm1,
                                                input logic signed [W-1:0] m);
    logic signed [W:0] mx;
    logic signed [W:0] sum;
    mx = {m[W-1], m};
    case ({qr[0], qm1})
      2'b01:   sum = acc + mx;
      2'b10:   sum = acc - mx;
      default: sum = acc;
    endcase
    return {sum[W], sum, qr};
  endfunction

  // One restoring-division iteration on magnitudes. The partial remainder
  // stays below the divisor (at most 2^(W-1)), so its MSB is always zero
  // and the shifted value still fits in W bits. Returns {rem, quo}.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] d);
    logic [W-1:0] rs;
    logic [W:0]   diff;
    rs   = {rem[W-2:0], quo[W-1]};
    diff = {1'b0, rs} - {1'b0, d};
    if (!diff[W]) begin
      return {diff[W-1:0], quo[W-2:0], 1'b1};
    end
    return {rs, quo[W-2:0], 1'b0};
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*W-1:0]      z_q, z_d;
  logic                div0_q, div0_d;

  logic                is_div_q, is_div_d;
  logic signed [W:0]   acc_q, acc_d;
  logic [W-1:0]        qr_q, qr_d;
  logic                qm1_q, qm1_d;
  logic signed [W-1:0] m_q, m_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;

  logic [2*W+1:0]      booth_r;
  logic [2*W-1:0]      div_r;
  logic signed [W:0]   b_acc;
  logic [W-1:0]        b_qr;
  logic                b_qm1;
  logic [W-1:0]        d_rem;
  logic [W-1:0]        d_quo;
  logic [W-1:0]        fin_quo;
  logic [W-1:0]        fin_rem;

  assign booth_r = booth_step(acc_q, qr_q, qm1_q, m_q);
  assign div_r   = div_step(acc_q[W-1:0], qr_q, m_q);
  assign b_acc   = booth_r[2*W+1:W+1];
  assign b_qr    = booth_r[W:1];
  assign b_qm1   = booth_r[0];
  assign d_rem   = div_r[2*W-1:W];
  assign d_quo   = div_r[W-1:0];
  // Quotient truncates toward zero; remainder follows the dividend sign.
  assign fin_quo = (sa_q ^ sb_q) ? -d_quo : d_quo;
  assign fin_rem = sa_q ? -d_rem : d_rem;

  // Next-state, iteration and result selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    z_d      = z_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          div0_d = 1'b0;
          if (bus.op == OP_MUL) begin
            is_div_d = 1'b0;
            acc_d    = '0;
            qr_d     = bus.b;
            qm1_d    = 1'b0;
            m_d      = bus.a;
            cnt_d    = CW'(W);
            state_d  = ST_RUN;
          end else if (bus.op == OP_DIV && bus.b != '0) begin
            is_div_d = 1'b1;
            acc_d    = '0;
            qr_d     = bus.a[W-1] ? -bus.a : bus.a;
            qm1_d    = 1'b0;
            m_d      = bus.b[W-1] ? -bus.b : bus.b;
            sa_d     = bus.a[W-1];
            sb_d     = bus.b[W-1];
            cnt_d    = CW'(W);
            state_d  = ST_RUN;
          end else if (bus.op == OP_DIV) begin
            z_d     = {bus.a, {W{1'b1}}};
            div0_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            z_d     = {{W{1'b0}}, simple_op(bus.op, bus.a, bus.b)};
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_d = {1'b0, d_rem};
          qr_d  = d_quo;
        end else begin
          acc_d = b_acc;
          qr_d  = b_qr;
          qm1_d = b_qm1;
        end
        // The last iteration lands its result in z on the same edge.
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          z_d     = is_div_q ? {fin_rem, fin_quo} : {b_acc[W-1:0], b_qr};
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, counter and visible results; cleared by clear_n.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      z_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      div0_q  <= div0_d;
    end
  end

  // Iteration datapath; only meaningful while RUN, so no reset needed.
  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    acc_q    <= acc_d;
    qr_q     <= qr_d;
    qm1_q    <= qm1_d;
    m_q      <= m_d;
    sa_q     <= sa_d;
    sb_q     <= sb_d;
  end

  assign bus.ready = (state_q == ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.z     = z_q;
  assign bus.div0  = div0_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed W=32 vectors, multi-cycle corner sequences,
// and randomized W=16 / W=8 regression against a behavioural model.
module tb_seq_alu;

  typedef struct {
    logic [63:0] z;
    logic        div0;
    int          t0;
    int          lat;
    string       nm;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] z;
    logic        div0;
    int          lat;
    string       nm;
  } vec_t;

  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        start_v;
  logic [3:0]  op_v;
  logic [63:0] a_v, b_v;
  int          sel;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        prev_done = 1'b0;

  logic        ready_m, done_m, div0_m;
  logic [63:0] z_m;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        vt[NV];

  seq_alu_if #(.W(32)) if32 ();
  seq_alu_if #(.W(16)) if16 ();
  seq_alu_if #(.W(8))  if8 ();

  seq_alu #(.W(32)) u_dut32 (.clk(clk), .clear_n(clear_n), .bus(if32));
  seq_alu #(.W(16)) u_dut16 (.clk(clk), .clear_n(clear_n), .bus(if16));
  seq_alu #(.W(8))  u_dut8  (.clk(clk), .clear_n(clear_n), .bus(if8));

  assign if32.start = start_v && (sel == 0);
  assign if32.op    = op_v;
  assign if32.a     = a_v[31:0];
  assign if32.b     = b_v[31:0];
  assign if16.start = start_v && (sel == 1);
  assign if16.op    = op_v;
  assign if16.a     = a_v[15:0];
  assign if16.b     = b_v[15:0];
  assign if8.start  = start_v && (sel == 2);
  assign if8.op     = op_v;
  assign if8.a      = a_v[7:0];
  assign if8.b      = b_v[7:0];

  always_comb begin
    ready_m = if32.ready;
    done_m  = if32.done;
    div0_m  = if32.div0;
    z_m     = if32.z;
    if (sel == 1) begin
      ready_m = if16.ready;
      done_m  = if16.done;
      div0_m  = if16.div0;
      z_m     = {32'd0, if16.z};
    end else if (sel == 2) begin
      ready_m = if8.ready;
      done_m  = if8.done;
      div0_m  = if8.div0;
      z_m     = {48'd0, if8.z};
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Behavioural reference: returns {div0, z} for width w.
  function automatic logic [64:0] model(input int w, input logic [3:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, ua, ub, r;
    longint      sa, sb, q, rm;
    int          amt;
    logic        d0;
    m   = (64'd1 << w) - 64'd1;
    ua  = a & m;
    ub  = b & m;
    sa  = ua[w-1] ? longint'(ua | ~m) : longint'(ua);
    sb  = ub[w-1] ? longint'(ub | ~m) : longint'(ub);
    amt = int'(ub[4:0]) & (w - 1);
    d0  = 1'b0;
    r   = 64'd0;
    case (op)
      4'd0:  r = (ua + ub) & m;
      4'd1:  r = (ua - ub) & m;
      4'd2: begin
        r = 64'(sa * sb);
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
      end
      4'd3: begin
        if (ub == 64'd0) begin
          r  = (ua << w) | m;
          d0 = 1'b1;
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = ((64'(rm) & m) << w) | (64'(q) & m);
        end
      end
      4'd4:  r = ua >> amt;
      4'd5:  r = 64'(sa >>> amt) & m;
      4'd6:  r = (ua << amt) & m;
      4'd7:  r = ((ua >> amt) | (ua << (w - amt))) & m;
      4'd8:  r = ((ua << amt) | (ua >> (w - amt))) & m;
      4'd9:  r = ua & ub;
      4'd10: r = ua | ub;
      4'd11: r = (-ua) & m;
      4'd12: r = (~ua) & m;
      default: r = 64'd0;
    endcase
    return {d0, r};
  endfunction

  // Scoreboard: pop and compare whenever the selected DUT pulses done.
  always @(negedge clk) begin
    if (clear_n === 1'b1 && done_m === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, "_z"}, z_m, mon_e.z);
        chk({mon_e.nm, "_div0"}, 64'(div0_m), 64'(mon_e.div0));
        chk({mon_e.nm, "_lat"}, 64'(cyc - mon_e.t0), 64'(mon_e.lat));
      end
    end
    if (prev_done) chk("done_one_cycle", 64'(done_m), 64'd0);
    prev_done = done_m;
  end

  task automatic wait_ready();
    int n = 0;
    while (ready_m !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(ready_m), 64'd1);
  endtask

  task automatic run_op(input int s, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] ez, input logic ed0,
                        input int elat, input string nm);
    exp_t e;
    int   n;
    sel = s;
    wait_ready();
    op_v    = op;
    a_v     = a;
    b_v     = b;
    start_v = 1'b1;
    e.z = ez; e.div0 = ed0; e.t0 = cyc; e.lat = elat; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    start_v = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 150) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_completed"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    int          nd;
    int          w;
    logic [3:0]  rop;
    logic [63:0] ra, rb, msk;
    logic [64:0] mr;

    vt[0]  = '{4'd0,  64'hFFFFFFFF, 64'd1,          64'h0000000000000000, 1'b0, 1,  "add_wrap"};
    vt[1]  = '{4'd1,  64'd5,        64'd7,          64'h00000000FFFFFFFE, 1'b0, 1,  "sub_neg"};
    vt[2]  = '{4'd2,  64'hFFFFFFFD, 64'd7,          64'hFFFFFFFFFFFFFFEB, 1'b0, 33, "mul_m3x7"};
    vt[3]  = '{4'd2,  64'h80000000, 64'h80000000,   64'h4000000000000000, 1'b0, 33, "mul_minmin"};
    vt[4]  = '{4'd3,  64'hFFFFFFF9, 64'd2,          64'hFFFFFFFFFFFFFFFD, 1'b0, 33, "div_m7d2"};
    vt[5]  = '{4'd3,  64'h80000000, 64'hFFFFFFFF,   64'h0000000080000000, 1'b0, 33, "div_min_m1"};
    vt[6]  = '{4'd3,  64'd9,        64'd0,          64'h00000009FFFFFFFF, 1'b1, 1,  "div_by0"};
    vt[7]  = '{4'd0,  64'd1,        64'd2,          64'h0000000000000003, 1'b0, 1,  "div0_clear"};
    vt[8]  = '{4'd7,  64'h80000001, 64'h21,         64'h00000000C0000000, 1'b0, 1,  "ror1"};
    vt[9]  = '{4'd8,  64'h80000001, 64'h21,         64'h0000000000000003, 1'b0, 1,  "rol1"};
    vt[10] = '{4'd5,  64'h80000001, 64'h21,         64'h00000000C0000000, 1'b0, 1,  "shra1"};
    vt[11] = '{4'd4,  64'h80000001, 64'h21,         64'h0000000040000000, 1'b0, 1,  "shr1"};
    vt[12] = '{4'd6,  64'h80000001, 64'h21,         64'h0000000000000002, 1'b0, 1,  "shl1"};
    vt[13] = '{4'd9,  64'hF0F0FF00, 64'h0FF0F0F0,   64'h0000000000F0F000, 1'b0, 1,  "and"};
    vt[14] = '{4'd10, 64'hF0F0FF00, 64'h0FF0F0F0,   64'h00000000FFF0FFF0, 1'b0, 1,  "or"};
    vt[15] = '{4'd11, 64'd5,        64'd0,          64'h00000000FFFFFFFB, 1'b0, 1,  "neg"};
    vt[16] = '{4'd12, 64'd0,        64'd0,          64'h00000000FFFFFFFF, 1'b0, 1,  "not"};
    vt[17] = '{4'd13, 64'hFFFF,     64'd1,          64'h0000000000000000, 1'b0, 1,  "reserved13"};
    vt[18] = '{4'd6,  64'h12345678, 64'h20,         64'h0000000012345678, 1'b0, 1,  "shl_amt0"};
    vt[19] = '{4'd3,  64'd7,        64'hFFFFFFFE,   64'h00000001FFFFFFFD, 1'b0, 33, "div_7dm2"};
    vt[20] = '{4'd2,  64'h7FFFFFFF, 64'h7FFFFFFF,   64'h3FFFFFFF00000001, 1'b0, 33, "mul_maxmax"};
    vt[21] = '{4'd2,  64'h80000000, 64'd1,          64'hFFFFFFFF80000000, 1'b0, 33, "mul_minx1"};

    clear_n = 1'b0;
    start_v = 1'b0;
    op_v    = 4'd0;
    a_v     = 64'd0;
    b_v     = 64'd0;
    sel     = 0;
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    chk("rst_ready", 64'(ready_m), 64'd1);
    chk("rst_done",  64'(done_m),  64'd0);
    chk("rst_z",     z_m,          64'd0);
    chk("rst_div0",  64'(div0_m),  64'd0);

    for (int i = 0; i < NV; i++)
      run_op(0, vt[i].op, vt[i].a, vt[i].b, vt[i].z, vt[i].div0, vt[i].lat, vt[i].nm);

    // start held high with other ops while a MUL is running
    sel = 0;
    wait_ready();
    op_v    = 4'd2;
    a_v     = 64'hFFFFFFFD;
    b_v     = 64'd7;
    start_v = 1'b1;
    sb.push_back('{64'hFFFFFFFFFFFFFFEB, 1'b0, cyc, 33, "hs_mul"});
    nd = 0;
    while (nd < 60) begin
      @(negedge clk);
      nd++;
      if (done_m) break;
      chk("hs_ready_low", 64'(ready_m), 64'd0);
      op_v = (nd % 2 == 1) ? 4'd0 : 4'd3;
      a_v  = {$urandom, $urandom};
      b_v  = {$urandom, $urandom};
    end
    start_v = 1'b0;
    chk("hs_done_seen", 64'(done_m), 64'd1);
    @(negedge clk);
    sb.delete();

    // reset in the middle of a MUL aborts it without a done pulse
    wait_ready();
    op_v    = 4'd2;
    a_v     = 64'd1234;
    b_v     = 64'd99;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    repeat (5) @(negedge clk);
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    chk("midrst_ready", 64'(ready_m), 64'd1);
    chk("midrst_done",  64'(done_m),  64'd0);
    chk("midrst_z",     z_m,          64'd0);
    chk("midrst_div0",  64'(div0_m),  64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_m) nd++;
    end
    chk("midrst_no_done", 64'(nd), 64'd0);

    // randomized regression on the narrow instances
    for (int s = 1; s <= 2; s++) begin
      w   = (s == 1) ? 16 : 8;
      msk = (64'd1 << w) - 64'd1;
      for (int k = 0; k < 60; k++) begin
        rop = 4'($urandom_range(0, 15));
        ra  = {$urandom, $urandom};
        rb  = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) rb = 64'd0;
        if ($urandom_range(0, 9) == 0) begin
          ra = 64'd1 << (w - 1);
          rb = msk;
        end
        mr = model(w, rop, ra, rb);
        run_op(s, rop, ra, rb, mr[63:0], mr[64],
               (rop == 4'd2 || (rop == 4'd3 && (rb & msk) != 64'd0)) ? w + 1 : 1,
               $sformatf("rnd_w%0d_op%0d", w, rop));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, registered ALU for the miniSRC datapath. It replaces the purely combinational ALU.
- Simple operations complete in one cycle.
- Signed multiply runs as radix-2 Booth, one iteration per cycle.
- Signed divide runs as restoring division, one iteration per cycle.
- Start/done handshake with the control unit; a 2W-bit result feeds the HI/LO and Z registers.

Parameters:
W, 32, operand width; must be a power of two, at least 4
SW, log2(W), width of the shift/rotate amount field (derived; do not override)

Ports:
clk  in  1  system clock; all state updates on rising edge
clear_n  in  1  reset, synchronous, active-low
start  in  1  request; sampled only when ready=1
op  in  4  operation code, captured with start
a  in  W  operand A, captured with start
b  in  W  operand B, captured with start
ready  out  1  1 when idle and able to accept start
done  out  1  one-cycle pulse; z is valid from this cycle on
z  out  2W  result; held until the next accepted start
div0  out  1  sticky flag for the last op: DIV with b=0

Behaviour:
- Reset (clear_n=0 at a clock edge):
  - State goes to IDLE.
  - Outputs: z=0, done=0, div0=0, ready=1.
  - The iteration counter is cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- Op codes:
  - 0 ADD, 1 SUB, 2 MUL, 3 DIV.
  - 4 SHR (logical), 5 SHRA (arithmetic), 6 SHL, 7 ROR, 8 ROL.
  - 9 AND, 10 OR, 11 NEG (two's complement of a), 12 NOT (~a).
  - 13-15 reserved: result 0, one-cycle latency.
- Width rules:
  - For all ops except MUL/DIV, z[2W-1:W]=0 and the result is in z[W-1:0].
  - ADD/SUB wrap modulo 2^W.
  - Shift/rotate amount is b[SW-1:0]; upper bits of b are ignored. Amount 0 returns a unchanged.
- MUL: signed a × signed b; the full 2W-bit two's-complement product goes to z.
- DIV: signed, quotient truncated toward zero.
  - z[W-1:0] = quotient (LO), z[2W-1:W] = remainder (HI).
  - Remainder takes the sign of the dividend.
  - a = most-negative, b = -1: quotient = most-negative, remainder = 0.
- Divide by zero:
  - Completes with single-cycle latency.
  - z[W-1:0] = all ones, z[2W-1:W] = a, div0=1.
- State machine:
  - IDLE: ready=1.
    - start=1 with op MUL, or DIV with b≠0: capture operands, load counter = W, go to RUN.
    - start=1 with any other op (including DIV with b=0): compute the result into z, go to DONE.
    - Otherwise stay in IDLE.
  - RUN: ready=0. One Booth or restoring step per cycle, counter decrements; when it reaches 0, go to DONE with the final result latched into z.
  - DONE: done=1 for exactly this cycle, ready=0; unconditionally return to IDLE.
- Latency, counted from the edge that samples start:
  - Single-cycle ops: done high in the next cycle.
  - MUL/DIV: done high W+1 cycles later.
  - Next start is accepted one cycle after done (throughput is one simple op per 2 cycles).
- Ignored inputs:
  - start while ready=0 is ignored; no queuing.
  - a, b and op changing during RUN have no effect (operands are registered).
- Result and flag timing:
  - z updates only in the cycle done rises, and holds through subsequent IDLE cycles.
  - div0 is updated on each accepted start (cleared, or set for the DIV-by-0 case).
- No combinational path from inputs to any output.

Test Plan:
- Reset: hold clear_n=0 for 2 cycles mid-MUL -> ready=1, done=0, z=0, div0=0; no done pulse afterwards.
- ADD/SUB, W=32:
  - a=0xFFFFFFFF, b=1, ADD -> z=0x0 one cycle later.
  - a=5, b=7, SUB -> z[31:0]=0xFFFFFFFE, z[63:32]=0.
  - done pulses exactly 1 cycle.
- MUL, W=32:
  - a=-3, b=7 -> z=0xFFFFFFFFFFFFFFEB, done exactly 33 cycles after start, ready=0 throughout.
  - a=0x80000000, b=0x80000000 -> z=0x4000000000000000.
- DIV, W=32:
  - a=-7, b=2 -> LO=-3, HI=-1 after 33 cycles.
  - a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
  - a=9, b=0 -> one-cycle latency, LO=0xFFFFFFFF, HI=9, div0=1; the next op clears div0.
- Shift/rotate:
  - a=0x80000001, b=0x21 (amount 1): ROR -> 0xC0000000, ROL -> 0x00000003, SHRA -> 0xC0000000, SHR -> 0x40000000, SHL -> 0x00000002.
- Handshake: assert start every cycle during a MUL with a different op -> ignored, z=MUL result. Repeat the regression with W=8 and W=16 for randomized ops against a software model.
